voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 156 +++++++++++++++
 tb/tb_voice_allocator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice allocator driving per-voice ADSR new/release triggers.
// Optional macro VOICE_STEAL_EN: steal the oldest gated voice when every voice is gated.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_valid,
    input  logic                    note_on,
    input  logic [6:0]              note_num,
    output logic                    note_ready,
    input  logic [NUM_VOICES-1:0]   voice_busy,
    output logic [NUM_VOICES-1:0]   new_note_pulse,
    output logic [NUM_VOICES-1:0]   release_note_pulse,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic                    drop_pulse
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                  state_q, state_d;
    logic [NUM_VOICES-1:0]   gate_q, new_q, rel_q;
    logic [7*NUM_VOICES-1:0] note_q;
    logic [AGE_W-1:0]        age_q [NUM_VOICES];
    logic                    drop_q;
    logic                    accept;

    logic             hit_found, free_found, old_found, sel_found;
    logic [IDX_W-1:0] hit_idx, free_idx, old_idx, sel_idx;
    logic [AGE_W-1:0] old_age;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0] steal_idx;
    logic [AGE_W-1:0] steal_age;
`endif

    assign note_ready = (state_q == StIdle) && !rst;
    assign accept     = note_valid && note_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Candidate searches scan ascending so that ties resolve to the lowest index.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        old_found  = 1'b0;
        old_idx    = '0;
        old_age    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!hit_found && gate_q[v] && note_q[7*v +: 7] == note_num) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(v);
            end
            if (!free_found && !gate_q[v] && !voice_busy[v]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
            if (!gate_q[v] && (!old_found || age_q[v] > old_age)) begin
                old_found = 1'b1;
                old_idx   = IDX_W'(v);
                old_age   = age_q[v];
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Only consulted when all voices are gated, so every voice is a candidate.
    always_comb begin
        steal_idx = '0;
        steal_age = age_q[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > steal_age) begin
                steal_idx = IDX_W'(v);
                steal_age = age_q[v];
            end
        end
    end
`endif

    always_comb begin
        sel_found = 1'b1;
        sel_idx   = hit_idx;
        if (!hit_found) begin
            if (free_found) begin
                sel_idx = free_idx;
            end else if (old_found) begin
                sel_idx = old_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                sel_idx = steal_idx;
`else
                sel_found = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gate_q  <= '0;
            note_q  <= '0;
            new_q   <= '0;
            rel_q   <= '0;
            drop_q  <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= '0;
        end else begin
            state_q <= state_d;
            new_q   <= '0;
            rel_q   <= '0;
            drop_q  <= 1'b0;
            if (accept) begin
                if (note_on) begin
                    if (sel_found) begin
                        new_q[sel_idx]          <= 1'b1;
                        gate_q[sel_idx]         <= 1'b1;
                        note_q[7*sel_idx +: 7]  <= note_num;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (IDX_W'(v) == sel_idx) begin
                                age_q[v] <= '0;
                            end else if (age_q[v] != '1) begin
                                age_q[v] <= age_q[v] + 1'b1;
                            end
                        end
                    end else begin
                        drop_q <= 1'b1;
                    end
                end else if (hit_found) begin
                    rel_q[hit_idx]  <= 1'b1;
                    gate_q[hit_idx] <= 1'b0;
                end else begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

    // Reset during the issue cycle masks the pending pulses immediately.
    assign new_note_pulse     = rst ? '0 : new_q;
    assign release_note_pulse = rst ? '0 : rel_q;
    assign drop_pulse         = rst ? 1'b0 : drop_q;
    assign voice_note         = note_q;
    assign voice_gate         = gate_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus randomized events
// compared against an array-based allocation model.
module tb_voice_allocator;
    localparam int NV      = 4;
    localparam int AGE_MAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          note_valid = 1'b0;
    logic          note_on = 1'b0;
    logic [6:0]    note_num = '0;
    logic [NV-1:0] voice_busy = '0;
    logic          note_ready;
    logic [NV-1:0] new_note_pulse, release_note_pulse, voice_gate;
    logic [7*NV-1:0] voice_note;
    logic          drop_pulse;

    int checks = 0;
    int errors = 0;

    bit         m_gate [NV];
    logic [6:0] m_note [NV];
    int         m_age  [NV];
    logic [NV-1:0] exp_new, exp_rel;
    logic          exp_drop;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .note_valid         (note_valid),
        .note_on            (note_on),
        .note_num           (note_num),
        .note_ready         (note_ready),
        .voice_busy         (voice_busy),
        .new_note_pulse     (new_note_pulse),
        .release_note_pulse (release_note_pulse),
        .voice_note         (voice_note),
        .voice_gate         (voice_gate),
        .drop_pulse         (drop_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_gate_vec();
        logic [31:0] r = '0;
        for (int v = 0; v < NV; v++) r[v] = m_gate[v];
        return r;
    endfunction

    function automatic logic [31:0] m_note_vec();
        logic [31:0] r = '0;
        for (int v = 0; v < NV; v++) r[7*v +: 7] = m_note[v];
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 1'b0;
            m_note[v] = '0;
            m_age[v]  = 0;
        end
    endtask

    // Allocation rules: retrigger match, free idle voice, oldest released voice, then steal/drop.
    task automatic model_apply(input bit on, input logic [6:0] num, input logic [NV-1:0] busy,
                               output logic [NV-1:0] en, output logic [NV-1:0] er,
                               output logic ed);
        int sel = -1;
        int best = -1;
        en = '0;
        er = '0;
        ed = 1'b0;
        for (int v = 0; v < NV; v++)
            if (sel < 0 && m_gate[v] && m_note[v] == num) sel = v;
        if (on) begin
            for (int v = 0; v < NV; v++)
                if (sel < 0 && !m_gate[v] && !busy[v]) sel = v;
            if (sel < 0)
                for (int v = 0; v < NV; v++)
                    if (!m_gate[v] && m_age[v] > best) begin
                        best = m_age[v];
                        sel  = v;
                    end
`ifdef VOICE_STEAL_EN
            if (sel < 0)
                for (int v = 0; v < NV; v++)
                    if (m_age[v] > best) begin
                        best = m_age[v];
                        sel  = v;
                    end
`endif
            if (sel < 0) begin
                ed = 1'b1;
            end else begin
                en[sel] = 1'b1;
                for (int v = 0; v < NV; v++)
                    if (v != sel && m_age[v] < AGE_MAX) m_age[v]++;
                m_age[sel]  = 0;
                m_gate[sel] = 1'b1;
                m_note[sel] = num;
            end
        end else if (sel < 0) begin
            ed = 1'b1;
        end else begin
            er[sel]     = 1'b1;
            m_gate[sel] = 1'b0;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "/gate"}, 32'(voice_gate), m_gate_vec());
        chk({tag, "/note"}, 32'(voice_note), m_note_vec());
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        note_valid = 1'b0;
        tick();
        chk({tag, "/ready_in_rst"}, 32'(note_ready), 32'd0);
        tick();
        chk({tag, "/gate"}, 32'(voice_gate), 32'd0);
        chk({tag, "/note"}, 32'(voice_note), 32'd0);
        chk({tag, "/new"}, 32'(new_note_pulse), 32'd0);
        chk({tag, "/rel"}, 32'(release_note_pulse), 32'd0);
        chk({tag, "/drop"}, 32'(drop_pulse), 32'd0);
        rst = 1'b0;
        #1;
        chk({tag, "/ready_after_rst"}, 32'(note_ready), 32'd1);
        model_reset();
    endtask

    task automatic send_event(input bit on, input logic [6:0] num, input logic [NV-1:0] busy,
                              input string tag);
        int n = 0;
        while (!note_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "/ready_pre"}, 32'(note_ready), 32'd1);
        note_valid = 1'b1;
        note_on    = on;
        note_num   = num;
        voice_busy = busy;
        model_apply(on, num, busy, exp_new, exp_rel, exp_drop);
        tick();
        // Scramble inputs during the issue cycle; the decision must already be fixed.
        note_valid = 1'b0;
        note_on    = 1'($urandom);
        note_num   = 7'($urandom);
        voice_busy = NV'($urandom);
        #1;
        chk({tag, "/new"}, 32'(new_note_pulse), 32'(exp_new));
        chk({tag, "/rel"}, 32'(release_note_pulse), 32'(exp_rel));
        chk({tag, "/drop"}, 32'(drop_pulse), 32'(exp_drop));
        chk({tag, "/ready_issue"}, 32'(note_ready), 32'd0);
        chk_state(tag);
        tick();
        chk({tag, "/pulses_clear"},
            32'({new_note_pulse, release_note_pulse, drop_pulse}), 32'd0);
        chk({tag, "/ready_back"}, 32'(note_ready), 32'd1);
    endtask

    bit            r_on;
    logic [6:0]    r_num;
    logic [NV-1:0] r_busy;

    initial begin
        // Reset and single note-on
        do_reset("rst0");
        send_event(1'b1, 7'd60, 4'b0000, "on60");
        chk("on60/v0note", 32'(voice_note[6:0]), 32'd60);

        // Fill all voices, release 62, reuse the released voice with everything busy
        send_event(1'b1, 7'd62, 4'b0000, "on62");
        send_event(1'b1, 7'd64, 4'b0000, "on64");
        send_event(1'b1, 7'd65, 4'b0000, "on65");
        send_event(1'b0, 7'd62, 4'b0000, "off62");
        chk("off62/gate_const", 32'(voice_gate), 32'b1101);
        send_event(1'b1, 7'd67, 4'b1111, "on67");
        chk("on67/v1note", 32'(voice_note[13:7]), 32'd67);

        // All voices gated with ages 3,2,1,0
        do_reset("rst1");
        send_event(1'b1, 7'd60, 4'b0000, "f60");
        send_event(1'b1, 7'd62, 4'b0000, "f62");
        send_event(1'b1, 7'd64, 4'b0000, "f64");
        send_event(1'b1, 7'd65, 4'b0000, "f65");
        send_event(1'b1, 7'd70, 4'b0000, "full70");
`ifdef VOICE_STEAL_EN
        chk("full70/v0note", 32'(voice_note[6:0]), 32'd70);
`else
        chk("full70/v0note", 32'(voice_note[6:0]), 32'd60);
`endif

        // Retrigger and unmatched note-off
        do_reset("rst2");
        send_event(1'b1, 7'd60, 4'b0000, "re60a");
        send_event(1'b1, 7'd60, 4'b0000, "re60b");
        chk("re60b/gate_const", 32'(voice_gate), 32'b0001);
        send_event(1'b0, 7'd61, 4'b0000, "off61");

        // note_valid held through issue: the second event waits for the next idle cycle
        do_reset("rst3");
        note_valid = 1'b1;
        note_on    = 1'b1;
        note_num   = 7'd60;
        voice_busy = '0;
        model_apply(1'b1, 7'd60, 4'b0000, exp_new, exp_rel, exp_drop);
        tick();
        note_num = 7'd62;
        chk("hold/a_new", 32'(new_note_pulse), 32'(exp_new));
        chk("hold/a_ready", 32'(note_ready), 32'd0);
        tick();
        chk("hold/idle_ready", 32'(note_ready), 32'd1);
        chk("hold/idle_new", 32'(new_note_pulse), 32'd0);
        model_apply(1'b1, 7'd62, 4'b0000, exp_new, exp_rel, exp_drop);
        tick();
        chk("hold/b_new", 32'(new_note_pulse), 32'(exp_new));
        chk_state("hold/b");
        note_num = 7'd64;
        tick();
        chk("hold/idle2_ready", 32'(note_ready), 32'd1);
        tick();
        // Event C accepted; reset in its issue cycle must mask the pulse
        rst = 1'b1;
        #1;
        chk("rstissue/new", 32'(new_note_pulse), 32'd0);
        chk("rstissue/drop", 32'(drop_pulse), 32'd0);
        chk("rstissue/ready", 32'(note_ready), 32'd0);
        tick();
        chk("rstissue/gate", 32'(voice_gate), 32'd0);
        chk("rstissue/note", 32'(voice_note), 32'd0);
        chk("rstissue/pulses",
            32'({new_note_pulse, release_note_pulse, drop_pulse}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstissue/ready_after", 32'(note_ready), 32'd1);
        note_valid = 1'b0;
        model_reset();
        tick();

        // Randomized traffic over a small note range to provoke matches and steals
        for (int i = 0; i < 300; i++) begin
            r_on   = ($urandom_range(99, 0) < 60);
            r_num  = 7'(60 + $urandom_range(7, 0));
            r_busy = NV'($urandom);
            send_event(r_on, r_num, r_busy, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
